conv_result_streamer: RTL and testbench
=======================================

# conv_result_streamer

Downstream consumer of the processor core's nine 32-bit convolution result words (output1..output9). On a capture strobe it snapshots all nine words, saturates each to an unsigned pixel, and streams them out one per beat over a valid/ready interface. It marks the last beat and counts completed windows, decoupling the core from a slower pixel sink such as a frame writer or UART bridge.

## Interface
- N, 9, number of result words per window (fixed at 9 for the 3x3 kernel; legal range 2..16)
- OUT_W, 8, output pixel width in bits; saturation ceiling is 2^OUT_W - 1
- CNT_W, 16, width of the completed-window counter
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- result_bus  in  32*N  packed core results; word k occupies bits [32k+31:32k] (output1 = word 0)
- capture  in  1  single-cycle strobe: snapshot result_bus and start a window
- out_ready  in  1  sink can accept a beat
- out_valid  out  1  beat available
- out_data  out  OUT_W  saturated pixel
- out_index  out  4  word index of the current beat, 0..N-1
- out_last  out  1  high on beat N-1
- busy  out  1  window in progress (state STREAM)
- overrun  out  1  sticky: capture arrived while busy and was dropped
- clear_err  in  1  synchronous clear of overrun
- window_count  out  CNT_W  number of completed windows, wraps modulo 2^CNT_W

## Operation
- States: IDLE, STREAM.
- IDLE: on capture=1, latch all N words into the snapshot registers, set idx=0, and go to STREAM.
- STREAM: out_valid=1, out_index=idx, out_data=sat(snap[idx]), out_last=(idx==N-1).
  - On out_valid&out_ready with idx<N-1: idx increments.
  - On out_valid&out_ready with idx==N-1: window_count increments.
    - If capture=1 in the same cycle, relatch, set idx=0, and stay in STREAM (back-to-back, no bubble, no overrun).
    - Otherwise go to IDLE.
- Saturation: treat the word as signed 32-bit. A negative value gives 0. A value above 2^OUT_W-1 gives 2^OUT_W-1. Otherwise the output is the low OUT_W bits.
- capture=1 in STREAM, except in the last-beat-accept cycle: the capture is ignored, the snapshot is unchanged, and overrun is set to 1.
- overrun is cleared by clear_err=1. If capture-while-busy and clear_err occur in the same cycle, set wins.
- Snapshot registers change only on an accepted capture. result_bus is never read combinationally onto out_data.
- out_data, out_index and out_last stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, idx=0, snapshot=0
  - out_valid=0, out_data=0, out_index=0, out_last=0
  - busy=0, overrun=0, window_count=0
- Latency: capture sampled at edge T puts the first beat (out_valid=1) in the cycle after T.
- With out_ready held at 1, a window takes exactly N cycles. busy falls in the cycle after the last handshake.
- All outputs are registered or decoded from registered state. There is no combinational path from out_ready to out_valid or out_data.
- window_count updates on the edge that accepts the last beat, and wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-window aborts the window with no count increment. The block resumes in IDLE after deassertion and needs a fresh capture.

## Test plan
- Basic stream:
  - Stimulus: words 0..8 = {0,1,50,100,200,255,128,7,9}, capture pulse, out_ready=1.
  - Response: 9 consecutive beats with those values in order, index 0..8, out_last only on index 8, window_count=1, busy low afterwards.
- Saturation:
  - Stimulus: words = {-1, 32'h80000000, 256, 32'h7FFFFFFF, 255, 0, 300, -200, 254}.
  - Response: out_data = {0,0,255,255,255,0,255,0,254}.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,... ; result_bus is changed after capture.
  - Response: data, index and last hold while out_ready=0. Every beat is delivered exactly once with the snapshot values, never the new result_bus values.
- Overrun:
  - Stimulus: capture at beat 3 of a window.
  - Response: overrun=1, the window completes with the original data, and no second window starts.
  - Stimulus: then clear_err=1.
  - Response: overrun=0.
- Back-to-back:
  - Stimulus: capture coincides with acceptance of beat 8.
  - Response: the next cycle shows index 0 of the new snapshot, overrun stays 0, window_count=2 after both windows.
- Reset mid-window:
  - Stimulus: assert reset asynchronously at beat 4.
  - Response: outputs go to their reset values immediately, window_count=0, and no beats appear until the next capture.

Source files
------------

// File: rtl/conv_result_streamer.sv
// conv_result_streamer: on a capture strobe it snapshots N 32-bit convolution results.
// It then streams them out one per valid/ready beat as saturated unsigned OUT_W-bit pixels.
module conv_result_streamer #(
   parameter int N     = 9,
   parameter int OUT_W = 8,
   parameter int CNT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [32*N-1:0]   result_bus,
   input  logic              capture,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data,
   output logic [3:0]        out_index,
   output logic              out_last,
   output logic              busy,
   output logic              overrun,
   input  logic              clear_err,
   output logic [CNT_W-1:0]  window_count
);
   // Handshake: a beat transfers on the rising edge where out_valid && out_ready. out_valid and
   // the beat payload depend only on registered state, and they hold while out_ready is low.
   localparam logic [0:0]       IDLE     = 1'b0;
   localparam logic [0:0]       STREAM   = 1'b1;
   localparam logic [3:0]       LAST_IDX = 4'(N - 1);
   localparam logic [OUT_W-1:0] SAT_MAX  = '1;

   logic [0:0]  state;
   logic [3:0]  idx;
   logic [31:0] snap [N];
   logic        accept;
   logic        last_accept;
   logic        load;
   logic        drop;

   function automatic logic [OUT_W-1:0] sat(input logic [31:0] w);
      if (w[31])
         return '0;
      else if ((w >> OUT_W) != 32'd0)
         return SAT_MAX;
      else
         return w[OUT_W-1:0];
   endfunction

   assign accept      = (state == STREAM) && out_ready;
   assign last_accept = accept && (idx == LAST_IDX);
   // A capture is taken when idle, or when it lines up with the final handshake (no bubble).
   assign load        = capture && ((state == IDLE) || last_accept);
   assign drop        = capture && (state == STREAM) && !last_accept;

   assign out_valid = (state == STREAM);
   assign busy      = (state == STREAM);
   assign out_index = idx;
   assign out_last  = (state == STREAM) && (idx == LAST_IDX);
   assign out_data  = (state == STREAM) ? sat(snap[idx]) : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         idx          <= '0;
         overrun      <= 1'b0;
         window_count <= '0;
         for (int k = 0; k < N; k++)
            snap[k] <= '0;
      end else begin
         if (load) begin
            state <= STREAM;
            idx   <= '0;
            for (int k = 0; k < N; k++)
               snap[k] <= result_bus[32*k +: 32];
         end else if (last_accept) begin
            state <= IDLE;
            idx   <= '0;
         end else if (accept) begin
            idx <= idx + 4'd1;
         end

         if (last_accept)
            window_count <= window_count + 1'b1;

         // A dropped capture outranks a simultaneous clear.
         if (drop)
            overrun <= 1'b1;
         else if (clear_err)
            overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_conv_result_streamer.sv
// Bench for conv_result_streamer: it applies table-driven windows and then hand-written sequences
// for backpressure, overrun, back-to-back capture and reset in the middle of a window.
module tb_conv_result_streamer;
   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [287:0]  result_bus;
   logic          capture;
   logic          out_ready;
   logic          out_valid;
   logic [7:0]    out_data;
   logic [3:0]    out_index;
   logic          out_last;
   logic          busy;
   logic          overrun;
   logic          clear_err;
   logic [15:0]   window_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string         name;
      logic [287:0]  words;
      logic [71:0]   exp;
   } vec_t;

   vec_t vecs [3];

   conv_result_streamer dut (
      .clock        (clock),
      .reset        (reset),
      .result_bus   (result_bus),
      .capture      (capture),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_index    (out_index),
      .out_last     (out_last),
      .busy         (busy),
      .overrun      (overrun),
      .clear_err    (clear_err),
      .window_count (window_count)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag, input logic [15:0] exp_count);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_index"}, out_index, 0);
      check({tag, "_last"}, out_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_overrun"}, overrun, 0);
      check({tag, "_count"}, window_count, exp_count);
   endtask

   task automatic do_capture(input logic [287:0] w);
      result_bus = w;
      capture    = 1'b1;
      tick();
      capture    = 1'b0;
   endtask

   // Streams beats until 'stop' have been accepted. With bp set, out_ready follows 1,0,0,...
   // At beat cap_beat it raises capture for one accepted cycle, with result_bus = alt.
   task automatic stream(input logic [71:0] exp, input bit bp, input int cap_beat,
                         input logic [287:0] alt, input int stop);
      int         beat = 0;
      int         cyc = 0;
      bit         held = 0;
      bit         cap_done = 0;
      logic [7:0] hd = '0;
      logic [3:0] hi = '0;
      logic       rdy;
      while (beat < stop && cyc < 200) begin
         rdy = bp ? (cyc % 3 == 0) : 1'b1;
         out_ready = rdy;
         if (beat == cap_beat && rdy && !cap_done) begin
            capture    = 1'b1;
            result_bus = alt;
            cap_done   = 1;
         end
         check("out_valid", out_valid, 1);
         if (held) begin
            check("hold_data", out_data, hd);
            check("hold_index", out_index, hi);
         end
         if (rdy) begin
            check("beat_data", out_data, exp[8*beat +: 8]);
            check("beat_index", out_index, beat[3:0]);
            check("beat_last", out_last, beat == 8);
            beat++;
            held = 0;
         end else begin
            held = 1;
            hd   = out_data;
            hi   = out_index;
         end
         tick();
         capture = 1'b0;
         cyc++;
      end
      check("stream_timeout", beat, stop);
   endtask

   initial begin
      capture    = 1'b0;
      out_ready  = 1'b0;
      clear_err  = 1'b0;
      result_bus = '0;

      vecs[0].name  = "basic";
      vecs[0].words = {32'd9, 32'd7, 32'd128, 32'd255, 32'd200, 32'd100, 32'd50, 32'd1, 32'd0};
      vecs[0].exp   = {8'd9, 8'd7, 8'd128, 8'd255, 8'd200, 8'd100, 8'd50, 8'd1, 8'd0};
      vecs[1].name  = "saturation";
      vecs[1].words = {32'd254, 32'hFFFFFF38, 32'd300, 32'd0, 32'd255, 32'h7FFFFFFF,
                       32'd256, 32'h80000000, 32'hFFFFFFFF};
      vecs[1].exp   = {8'd254, 8'd0, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0};
      vecs[2].name  = "boundary";
      vecs[2].words = {32'hFFFFFF00, 32'h40000000, 32'h00010000, 32'd253, 32'd128,
                       32'd127, 32'd64, 32'd32, 32'd16};
      vecs[2].exp   = {8'd0, 8'd255, 8'd255, 8'd253, 8'd128, 8'd127, 8'd64, 8'd32, 8'd16};

      #1 reset = 1'b1;
      #1 check_idle("reset", 16'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      check_idle("post_reset", 16'd0);

      for (int i = 0; i < 3; i++) begin
         do_capture(vecs[i].words);
         stream(vecs[i].exp, 1'b0, -1, '0, 9);
         check({vecs[i].name, "_busy_after"}, busy, 0);
         check({vecs[i].name, "_valid_after"}, out_valid, 0);
         check({vecs[i].name, "_count"}, window_count, 32'(i + 1));
      end

      // Backpressure with result_bus changed after the snapshot.
      do_capture(vecs[0].words);
      result_bus = ~vecs[0].words;
      stream(vecs[0].exp, 1'b1, -1, '0, 9);
      check("bp_busy_after", busy, 0);
      check("bp_count", window_count, 4);

      // Overrun: capture during beat 3 is dropped and the window keeps its original data.
      do_capture(vecs[1].words);
      stream(vecs[1].exp, 1'b0, 3, vecs[0].words, 9);
      check("ovr_flag", overrun, 1);
      check("ovr_count", window_count, 5);
      for (int i = 0; i < 3; i++) begin
         check("ovr_no_second_window", out_valid, 0);
         tick();
      end
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      check("ovr_cleared", overrun, 0);

      // A dropped capture in the same cycle as clear_err leaves overrun set.
      do_capture(vecs[2].words);
      out_ready = 1'b0;
      capture   = 1'b1;
      clear_err = 1'b1;
      tick();
      capture   = 1'b0;
      clear_err = 1'b0;
      check("set_wins", overrun, 1);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      check("set_wins_clear", overrun, 0);
      stream(vecs[2].exp, 1'b0, -1, '0, 9);
      check("set_wins_count", window_count, 6);

      reset = 1'b1;
      #1 check("pulse_reset_count", window_count, 0);
      tick();
      reset = 1'b0;

      // Back-to-back: the capture coincides with acceptance of beat 8.
      do_capture(vecs[0].words);
      stream(vecs[0].exp, 1'b0, 8, vecs[2].words, 9);
      check("b2b_valid", out_valid, 1);
      check("b2b_overrun", overrun, 0);
      check("b2b_count_mid", window_count, 1);
      stream(vecs[2].exp, 1'b0, -1, '0, 9);
      check("b2b_count", window_count, 2);
      check("b2b_busy_after", busy, 0);
      check("b2b_overrun_after", overrun, 0);

      // Reset asserted asynchronously while beat 4 is on the bus.
      do_capture(vecs[1].words);
      stream(vecs[1].exp, 1'b0, -1, '0, 4);
      check("mid_index_before", out_index, 4);
      #2 reset = 1'b1;
      #1 check_idle("mid_reset", 16'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mid_no_beats", out_valid, 0);
      end
      do_capture(vecs[0].words);
      stream(vecs[0].exp, 1'b0, -1, '0, 9);
      check("mid_recover_count", window_count, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
